// File: rtl/icache_param.sv
// ---------------------------------------------------------------------------
// icache_param
//   Direct-mapped, read-only instruction cache with parametrised geometry.
//   Hits are answered in the request cycle. A miss runs a BLK_WORDS-word
//   block fill over the iREN/iwait memory interface, one word per cycle in
//   which iwait is low. After the fill the line is validated, and the
//   re-issued fetch hits on the following cycle.
//
// Parameters
//   SETS       number of lines (power of 2, >= 2)
//   BLK_WORDS  32-bit words per line (power of 2, >= 1)
//   CNT_W      width of miss_count
//
// Ports
//   CLK         sole clock, rising edge
//   RST         synchronous, active-high reset
//   imemREN     datapath fetch request
//   imemaddr    fetch byte address; bits [1:0] are ignored
//   ihit        fetch served this cycle
//   imemload    fetched word; zero unless ihit
//   inval       invalidate all lines (one-cycle pulse); aborts a fill
//   iREN        memory read request (high for the whole fill)
//   iaddr       memory word address of the word being filled
//   iwait       memory busy; low while iREN is high means iload is valid
//   iload       memory read data
//   miss_count  number of fills started (wraps)
// ---------------------------------------------------------------------------
module icache_param #(
  parameter int SETS      = 16,
  parameter int BLK_WORDS = 2,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  input  logic             inval,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int OFF_B = $clog2(BLK_WORDS);
  // The word counter keeps at least one bit, even for one-word lines.
  localparam int CNT_B = (OFF_B > 0) ? OFF_B : 1;
  localparam int TAG_W = 32 - 2 - OFF_B - IDX_W;
  localparam logic [CNT_B-1:0] LAST_WORD = CNT_B'(BLK_WORDS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state;
  logic [SETS-1:0]    valid;
  logic [TAG_W-1:0]   tag_mem  [SETS];
  logic [31:0]        data_mem [SETS][BLK_WORDS];

  logic [TAG_W-1:0]   fill_tag;
  logic [IDX_W-1:0]   fill_idx;
  logic [CNT_B-1:0]   cnt;

  // Address split of the incoming fetch.
  logic [TAG_W-1:0]   addr_tag;
  logic [IDX_W-1:0]   addr_idx;
  logic [CNT_B-1:0]   addr_woff;

  assign addr_tag  = imemaddr[31 -: TAG_W];
  assign addr_idx  = imemaddr[2 + OFF_B +: IDX_W];
  // With one-word lines there is no offset field; the mask forces offset 0.
  assign addr_woff = imemaddr[2 +: CNT_B] & LAST_WORD;

  // The byte-select bits take no part in a word-wide cache.
  logic unused_byte_sel;
  assign unused_byte_sel = ^imemaddr[1:0];

  logic lookup_hit;   // tag lookup result, before inval suppression
  logic start_fill;
  logic fill_accept;  // a fill word is delivered this cycle
  logic fill_last;    // ... and it is the final word of the line

  // NOTE: every output of this block gets a default first, so no latches.
  always_comb begin
    lookup_hit  = 1'b0;
    ihit        = 1'b0;
    imemload    = '0;
    iREN        = 1'b0;
    iaddr       = '0;
    start_fill  = 1'b0;
    fill_accept = 1'b0;
    fill_last   = 1'b0;

    if (state == IDLE) begin
      lookup_hit = imemREN && valid[addr_idx] && (tag_mem[addr_idx] == addr_tag);
      // An inval pulse suppresses both the hit and a new fill in the same cycle.
      ihit       = lookup_hit && !inval;
      start_fill = imemREN && !lookup_hit && !inval;
      if (ihit) begin
        imemload = data_mem[addr_idx][addr_woff];
      end
    end else begin
      iREN        = 1'b1;
      iaddr       = {fill_tag, fill_idx, {(OFF_B + 2){1'b0}}} | (32'(cnt) << 2);
      fill_accept = !iwait;
      fill_last   = !iwait && (cnt == LAST_WORD);
    end
  end

  // Control state. RST outranks inval, which outranks fill completion.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      valid      <= '0;
      cnt        <= '0;
      fill_tag   <= '0;
      fill_idx   <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inval) begin
            valid <= '0;
          end else if (start_fill) begin
            fill_tag   <= addr_tag;
            fill_idx   <= addr_idx;
            cnt        <= '0;
            miss_count <= miss_count + 1'b1;
            // The old line is dropped at once, so a half-filled block can
            // never be mistaken for a valid one.
            valid[addr_idx] <= 1'b0;
            state           <= FILL;
          end
        end
        FILL: begin
          if (inval) begin
            valid <= '0;
            state <= IDLE;
          end else if (fill_accept) begin
            cnt <= cnt + 1'b1;
            if (fill_last) begin
              valid[fill_idx] <= 1'b1;
              state           <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays. Their contents are only observable through a set
  // valid bit, so a word written in an aborted cycle is harmless.
  // NOTE: the storage arrays are deliberately left out of reset; the valid
  // bits alone decide whether their contents are meaningful.
  always_ff @(posedge CLK) begin
    if (fill_accept) begin
      data_mem[fill_idx][cnt] <= iload;
    end
    if (fill_last) begin
      tag_mem[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_param.sv
// ---------------------------------------------------------------------------
// tb_icache_param
//   Self-checking bench for icache_param. The memory is a fixed function of
//   the word address. The reference model keeps only the per-set valid bit,
//   the tag and the number of fills started. Expected data always comes from
//   the memory function. miss_count is narrowed so that wrap-around is
//   reachable in a short run.
// ---------------------------------------------------------------------------
module tb_icache_param;

  localparam int SETS       = 16;
  localparam int BLK_WORDS  = 2;
  localparam int CNT_W      = 4;
  localparam int LINE_BYTES = BLK_WORDS * 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             imemREN;
  logic [31:0]      imemaddr;
  logic             ihit;
  logic [31:0]      imemload;
  logic             inval;
  logic             iREN;
  logic [31:0]      iaddr;
  logic             iwait;
  logic [31:0]      iload;
  logic [CNT_W-1:0] miss_count;

  int checks = 0;
  int errors = 0;

  bit          ref_valid [SETS];
  int unsigned ref_tag   [SETS];
  int unsigned ref_miss;

  icache_param #(.SETS(SETS), .BLK_WORDS(BLK_WORDS), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .inval(inval), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign iload = mem_fn(iaddr);

  function automatic int unsigned set_of(input logic [31:0] a);
    return (a / LINE_BYTES) % SETS;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a / (LINE_BYTES * SETS);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < SETS; i++) ref_valid[i] = 1'b0;
  endtask

  // Drive a fetch at the falling edge, then let the outputs settle.
  task automatic present(input logic [31:0] a, input logic do_inval);
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = a;
    inval    = do_inval;
    iwait    = 1'b1;
    #1;
  endtask

  // Follow a fill word by word. The fetch inputs are scrambled, which must
  // not disturb the fill. Optionally hold iwait for `hold` cycles mid-line.
  task automatic run_fill(input logic [31:0] a, input int hold);
    logic [31:0] base;
    int k;
    int held;
    int cyc;
    base = a - (a % LINE_BYTES);
    k    = 0;
    held = 0;
    cyc  = 0;
    while (k < BLK_WORDS && cyc < 100) begin
      @(negedge CLK);
      imemREN  = 1'($urandom_range(0, 1));
      imemaddr = $urandom;
      inval    = 1'b0;
      if (k == 1 && held < hold) begin
        iwait = 1'b1;
        held++;
      end else begin
        iwait = ($urandom_range(0, 3) == 0);
      end
      #1;
      check("fill_iren", {31'b0, iREN}, 32'd1);
      check("fill_iaddr", iaddr, base + 32'(4 * k));
      if (!iwait) k++;
      cyc++;
    end
    check("fill_done", k, BLK_WORDS);
  endtask

  // One fetch: check hit/miss against the model. On a miss, follow the
  // fill and confirm that the re-issued fetch hits on the next cycle.
  task automatic fetch(input logic [31:0] a, input int hold);
    bit h;
    int unsigned s;
    s = set_of(a);
    present(a, 1'b0);
    h = ref_valid[s] && (ref_tag[s] == tag_of(a));
    check("ihit", {31'b0, ihit}, {31'b0, h});
    check("imemload", imemload, h ? mem_fn(a & ~32'h3) : 32'h0);
    check("iren_idle", {31'b0, iREN}, 32'd0);
    if (!h) begin
      ref_valid[s] = 1'b0;
      ref_miss     = (ref_miss + 1) % (1 << CNT_W);
      run_fill(a, hold);
      ref_valid[s] = 1'b1;
      ref_tag[s]   = tag_of(a);
      check("miss_count", 32'(miss_count), ref_miss);
      present(a, 1'b0);
      check("refetch_hit", {31'b0, ihit}, 32'd1);
      check("refetch_data", imemload, mem_fn(a & ~32'h3));
    end
  endtask

  // inval pulse in IDLE while fetching: no hit, no fill, all lines dropped.
  task automatic inval_idle(input logic [31:0] a);
    present(a, 1'b1);
    check("inval_idle_ihit", {31'b0, ihit}, 32'd0);
    check("inval_idle_load", imemload, 32'h0);
    model_clear();
    @(negedge CLK);
    inval   = 1'b0;
    imemREN = 1'b0;
    #1;
    check("inval_idle_nofill", {31'b0, iREN}, 32'd0);
    check("inval_idle_count", 32'(miss_count), ref_miss);
  endtask

  // inval in the final fill cycle (word 1 may be delivered at the same time).
  task automatic inval_fill(input logic [31:0] a);
    logic [31:0] base;
    base = a - (a % LINE_BYTES);
    present(a, 1'b0);
    check("invf_miss", {31'b0, ihit}, 32'd0);
    ref_valid[set_of(a)] = 1'b0;
    ref_miss = (ref_miss + 1) % (1 << CNT_W);
    @(negedge CLK);
    imemREN = 1'b0;
    iwait   = 1'b0;
    #1;
    check("invf_iaddr0", iaddr, base);
    @(negedge CLK);
    inval = 1'b1;
    iwait = 1'($urandom_range(0, 1));
    #1;
    check("invf_iren", {31'b0, iREN}, 32'd1);
    model_clear();
    @(negedge CLK);
    inval = 1'b0;
    #1;
    check("invf_iren_drop", {31'b0, iREN}, 32'd0);
    check("invf_iaddr_zero", iaddr, 32'h0);
    check("invf_count", 32'(miss_count), ref_miss);
  endtask

  // Reset arriving in the middle of a fill.
  task automatic reset_in_fill(input logic [31:0] a);
    present(a, 1'b0);
    @(negedge CLK);
    iwait = 1'b0;
    #1;
    check("rstf_iren", {31'b0, iREN}, 32'd1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST     = 1'b0;
    imemREN = 1'b0;
    #1;
    model_clear();
    ref_miss = 0;
    check("rstf_ihit", {31'b0, ihit}, 32'd0);
    check("rstf_iren", {31'b0, iREN}, 32'd0);
    check("rstf_iaddr", iaddr, 32'h0);
    check("rstf_count", 32'(miss_count), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int guard;
    RST      = 1'b1;
    imemREN  = 1'b0;
    imemaddr = '0;
    inval    = 1'b0;
    iwait    = 1'b1;
    model_clear();
    ref_miss = 0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    check("rst_ihit", {31'b0, ihit}, 32'd0);
    check("rst_iren", {31'b0, iREN}, 32'd0);
    check("rst_iaddr", iaddr, 32'h0);
    check("rst_imemload", imemload, 32'h0);
    check("rst_count", 32'(miss_count), 32'd0);

    // First miss, then a hit on the other word of the line.
    fetch(32'h0000_0040, 0);
    fetch(32'h0000_0044, 0);
    // Same-set conflict: 0x440 evicts 0x40, which then misses again.
    fetch(32'h0000_0440, 0);
    fetch(32'h0000_0040, 0);
    check("conflict_count", 32'(miss_count), 32'd3);
    // Memory stalls for five cycles between the two words.
    fetch(32'h0000_00C4, 5);
    // inval during fill; afterwards 0x80 and 0x40 both miss.
    inval_fill(32'h0000_0080);
    fetch(32'h0000_0080, 0);
    fetch(32'h0000_0040, 0);
    inval_idle(32'h0000_0040);
    fetch(32'h0000_0040, 0);

    // Randomized traffic over a small address space for a mix of hits and conflicts.
    for (int n = 0; n < 150; n++) begin
      a = ($urandom_range(0, 2) << 7) | ($urandom_range(0, 15) << 3) |
          ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) inval_idle(a);
      else fetch(a, $urandom_range(0, 3));
    end

    // Run miss_count up to all-ones, then one more miss wraps it to zero.
    guard = 0;
    while (ref_miss != (1 << CNT_W) - 1 && guard < 64) begin
      fetch(((guard % 2) == 0) ? 32'h0000_0100 : 32'h0000_0500, 0);
      guard++;
    end
    check("count_all_ones", 32'(miss_count), (1 << CNT_W) - 1);
    fetch(32'h0000_0900, 0);
    check("count_wrap", 32'(miss_count), 32'd0);

    // Reset mid-fill; afterwards previously cached lines miss.
    reset_in_fill(32'h0000_0D40);
    fetch(32'h0000_0900, 0);
    fetch(32'h0000_0044, 0);

    @(negedge CLK);
    imemREN = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
